// File: rtl/hazard_fwd_unit.sv
// Forwarding/hazard unit for the 5-stage pipeline: per-operand forwarding selects,
// ID stall generation, HI/LO multiply/divide busy tracking and a stall counter.
module hazard_fwd_unit #(
   parameter int NUM_FWD      = 3,
   parameter int MUL_CYCLES   = 2,
   parameter int DIV_CYCLES   = 33,
   parameter int BR_EXE_STALL = 1,
   parameter int SEL_W        = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 id_valid_i,
   input  logic [4:0]           id_rs_i,
   input  logic [4:0]           id_rt_i,
   input  logic                 id_use_rs_i,
   input  logic                 id_use_rt_i,
   input  logic                 id_is_branch_i,
   input  logic                 id_use_hilo_i,
   input  logic [NUM_FWD-1:0]   stg_wen_i,
   input  logic [5*NUM_FWD-1:0] stg_reg_i,
   input  logic [NUM_FWD-1:0]   stg_is_load_i,
   input  logic                 md_start_i,
   input  logic                 md_is_div_i,
   output logic [SEL_W-1:0]     fwd_a_o,
   output logic [SEL_W-1:0]     fwd_b_o,
   output logic                 stall_id_o,
   output logic                 md_busy_o,
   output logic                 md_done_o,
   output logic                 md_overlap_o,
   output logic [31:0]          stall_cnt_o
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdState_t;

   mdState_t          state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              overlap_q, overlap_d;
   logic [31:0]       stallCnt_q, stallCnt_d;

   logic              hitA, hitB;
   logic              loadA, loadB;
   logic              exeA, exeB;
   logic [SEL_W-1:0]  selA, selB;
   logic              loadUseHaz, branchHaz, hiloHaz;
   logic              mdBusy;

   // Walk from the farthest stage toward EXE so the nearest match is the one left standing.
   always_comb begin
      hitA  = 1'b0;
      hitB  = 1'b0;
      loadA = 1'b0;
      loadB = 1'b0;
      exeA  = 1'b0;
      exeB  = 1'b0;
      selA  = '0;
      selB  = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (stg_wen_i[k] && (stg_reg_i[5*k +: 5] != 5'd0) && (stg_reg_i[5*k +: 5] == id_rs_i)) begin
            hitA  = 1'b1;
            loadA = stg_is_load_i[k];
            exeA  = (k == 0);
            selA  = SEL_W'(k + 1);
         end
         if (stg_wen_i[k] && (stg_reg_i[5*k +: 5] != 5'd0) && (stg_reg_i[5*k +: 5] == id_rt_i)) begin
            hitB  = 1'b1;
            loadB = stg_is_load_i[k];
            exeB  = (k == 0);
            selB  = SEL_W'(k + 1);
         end
      end
   end

   always_comb begin
      fwd_a_o    = (id_use_rs_i && hitA && !loadA) ? selA : '0;
      fwd_b_o    = (id_use_rt_i && hitB && !loadB) ? selB : '0;
      loadUseHaz = (id_use_rs_i && hitA && loadA) || (id_use_rt_i && hitB && loadB);
      branchHaz  = id_is_branch_i && (BR_EXE_STALL != 0) &&
                   ((id_use_rs_i && hitA && exeA) || (id_use_rt_i && hitB && exeB));
      hiloHaz    = id_use_hilo_i && mdBusy;
      stall_id_o = id_valid_i && (loadUseHaz || branchHaz || hiloHaz);
   end

   // HI/LO occupancy: a start while BUSY is dropped but remembered as a sticky error.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      overlap_d = overlap_q;
      mdBusy    = 1'b0;
      md_done_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (md_start_i) begin
               state_d = BUSY;
               cnt_d   = md_is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end
         end
         BUSY: begin
            mdBusy = 1'b1;
            if (md_start_i) begin
               overlap_d = 1'b1;
            end
            if (cnt_q <= CNT_W'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            md_done_o = 1'b1;
            if (md_start_i) begin
               state_d = BUSY;
               cnt_d   = md_is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stall_id_o && (stallCnt_q != 32'hFFFF_FFFF)) begin
         stallCnt_d = stallCnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         overlap_q  <= 1'b0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overlap_q  <= overlap_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   assign md_busy_o    = mdBusy;
   assign md_overlap_o = overlap_q;
   assign stall_cnt_o  = stallCnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit: forwarding priority, load-use and
// branch stalls, HI/LO busy timing, overlap flag, reset abort and counter saturation.
module tb_hazard_fwd_unit;

   logic        clk;
   logic        rst;
   logic        idValid;
   logic [4:0]  idRs;
   logic [4:0]  idRt;
   logic        idUseRs;
   logic        idUseRt;
   logic        idIsBranch;
   logic        idUseHilo;
   logic [2:0]  stgWen;
   logic [14:0] stgReg;
   logic [2:0]  stgIsLoad;
   logic        mdStart;
   logic        mdIsDiv;
   logic [1:0]  fwdA;
   logic [1:0]  fwdB;
   logic        stallId;
   logic        mdBusy;
   logic        mdDone;
   logic        mdOverlap;
   logic [31:0] stallCnt;

   int total = 0;
   int bad   = 0;

   hazard_fwd_unit #(
      .NUM_FWD(3), .MUL_CYCLES(2), .DIV_CYCLES(33), .BR_EXE_STALL(1), .SEL_W(2)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
      .id_use_rs_i(idUseRs), .id_use_rt_i(idUseRt),
      .id_is_branch_i(idIsBranch), .id_use_hilo_i(idUseHilo),
      .stg_wen_i(stgWen), .stg_reg_i(stgReg), .stg_is_load_i(stgIsLoad),
      .md_start_i(mdStart), .md_is_div_i(mdIsDiv),
      .fwd_a_o(fwdA), .fwd_b_o(fwdB), .stall_id_o(stallId),
      .md_busy_o(mdBusy), .md_done_o(mdDone), .md_overlap_o(mdOverlap),
      .stall_cnt_o(stallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; everything is sampled 1 time unit later.
   task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                input logic useRs, input logic useRt, input logic isBr,
                                input logic hilo, input logic [2:0] wen,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] ld);
      @(negedge clk);
      idValid    = valid;
      idRs       = rs;
      idRt       = rt;
      idUseRs    = useRs;
      idUseRt    = useRt;
      idIsBranch = isBr;
      idUseHilo  = hilo;
      stgWen     = wen;
      stgReg     = {r2, r1, r0};
      stgIsLoad  = ld;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; mdStart = 1'b0; mdIsDiv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      rst = 1'b0;
      checkOutput("rst_busy", 32'(mdBusy), 32'd0);
      checkOutput("rst_done", 32'(mdDone), 32'd0);
      checkOutput("rst_overlap", 32'(mdOverlap), 32'd0);
      checkOutput("rst_cnt", stallCnt, 32'd0);
      checkOutput("rst_stall", 32'(stallId), 32'd0);
      checkOutput("rst_fwda", 32'(fwdA), 32'd0);

      // Forwarding priority
      applyStimulus(1, 5, 0, 1, 0, 0, 0, 3'b001, 5, 0, 0, 3'b000);
      checkOutput("exe_fwda", 32'(fwdA), 32'd1);
      checkOutput("exe_stall", 32'(stallId), 32'd0);
      applyStimulus(1, 5, 0, 1, 0, 0, 0, 3'b011, 5, 5, 0, 3'b000);
      checkOutput("nearest_fwda", 32'(fwdA), 32'd1);
      applyStimulus(1, 5, 0, 1, 0, 0, 0, 3'b110, 5, 5, 5, 3'b000);
      checkOutput("mem_fwda", 32'(fwdA), 32'd2);
      applyStimulus(1, 5, 0, 1, 0, 0, 0, 3'b100, 0, 0, 5, 3'b000);
      checkOutput("wb_fwda", 32'(fwdA), 32'd3);

      // Load-use on rt, then resolved from MEM
      applyStimulus(1, 1, 7, 1, 1, 0, 0, 3'b001, 7, 0, 0, 3'b001);
      checkOutput("lu_stall", 32'(stallId), 32'd1);
      checkOutput("lu_fwdb", 32'(fwdB), 32'd0);
      applyStimulus(1, 1, 7, 1, 1, 0, 0, 3'b010, 0, 7, 0, 3'b000);
      checkOutput("lu_mem_fwdb", 32'(fwdB), 32'd2);
      checkOutput("lu_mem_stall", 32'(stallId), 32'd0);

      // Register zero and unused operand
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 3'b001, 0, 0, 0, 3'b001);
      checkOutput("r0_fwda", 32'(fwdA), 32'd0);
      checkOutput("r0_stall", 32'(stallId), 32'd0);
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 3'b001, 5, 0, 0, 3'b000);
      checkOutput("unused_fwda", 32'(fwdA), 32'd0);

      // Nearest is a load even though MEM holds a usable copy
      applyStimulus(1, 1, 7, 0, 1, 0, 0, 3'b011, 7, 7, 0, 3'b001);
      checkOutput("near_load_stall", 32'(stallId), 32'd1);
      checkOutput("near_load_fwdb", 32'(fwdB), 32'd0);
      applyStimulus(0, 1, 7, 0, 1, 0, 0, 3'b011, 7, 7, 0, 3'b001);
      checkOutput("invalid_stall", 32'(stallId), 32'd0);

      // Branch compare against EXE result
      applyStimulus(1, 3, 0, 1, 0, 1, 0, 3'b001, 3, 0, 0, 3'b000);
      checkOutput("br_exe_stall", 32'(stallId), 32'd1);
      applyStimulus(1, 3, 0, 1, 0, 1, 0, 3'b010, 0, 3, 0, 3'b000);
      checkOutput("br_mem_fwda", 32'(fwdA), 32'd2);
      checkOutput("br_mem_stall", 32'(stallId), 32'd0);
      applyStimulus(1, 3, 0, 1, 0, 1, 0, 3'b010, 0, 3, 0, 3'b010);
      checkOutput("br_memload_stall", 32'(stallId), 32'd1);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("cnt_after_fwd", stallCnt, 32'd4);

      // Divide: start at t0, overlap start at t5, mflo waits from t10
      mdStart = 1'b1; mdIsDiv = 1'b1;
      for (int t = 1; t <= 35; t++) begin
         if (t == 10)
            applyStimulus(1, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 3'b000);
         else
            applyStimulus(idValid, 0, 0, 0, 0, 0, idUseHilo, 3'b000, 0, 0, 0, 3'b000);
         mdStart = (t == 5);
         checkOutput($sformatf("div_busy_t%0d", t), 32'(mdBusy), 32'((t >= 1) && (t <= 33)));
         checkOutput($sformatf("div_done_t%0d", t), 32'(mdDone), 32'(t == 34));
         checkOutput($sformatf("div_stall_t%0d", t), 32'(stallId), 32'((t >= 10) && (t <= 33)));
         if (t == 5) checkOutput("overlap_before", 32'(mdOverlap), 32'd0);
         if (t == 6) checkOutput("overlap_set", 32'(mdOverlap), 32'd1);
      end
      checkOutput("overlap_held", 32'(mdOverlap), 32'd1);
      checkOutput("cnt_after_div", stallCnt, 32'd28);

      // Reset clears sticky state
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("rst2_overlap", 32'(mdOverlap), 32'd0);
      checkOutput("rst2_cnt", stallCnt, 32'd0);

      // Multiply with back-to-back restart from DONE
      mdStart = 1'b1; mdIsDiv = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      mdStart = 1'b0;
      checkOutput("mul_busy_t1", 32'(mdBusy), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("mul_busy_t2", 32'(mdBusy), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("mul_done_t3", 32'(mdDone), 32'd1);
      checkOutput("mul_notbusy_t3", 32'(mdBusy), 32'd0);
      mdStart = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      mdStart = 1'b0;
      checkOutput("restart_busy", 32'(mdBusy), 32'd1);
      checkOutput("restart_done", 32'(mdDone), 32'd0);
      checkOutput("restart_overlap", 32'(mdOverlap), 32'd0);

      // Reset mid-operation aborts without a done pulse
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(mdBusy), 32'd0);
      checkOutput("abort_done", 32'(mdDone), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("abort_done_next", 32'(mdDone), 32'd0);

      // Reset beats a simultaneous start
      rst = 1'b1; mdStart = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      rst = 1'b0; mdStart = 1'b0;
      checkOutput("rst_prio_busy", 32'(mdBusy), 32'd0);

      // Counter saturation from a preloaded near-full value
      force dut.stallCnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stallCnt_q;
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 7, 0, 1, 0, 0, 3'b001, 7, 0, 0, 3'b001);
      checkOutput("sat_stall", 32'(stallId), 32'd1);
      checkOutput("sat_cnt", stallCnt, 32'hFFFF_FFFF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);
      checkOutput("sat_cnt_hold", stallCnt, 32'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
